// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Owns the register-file write port: post-reset clear of x1..x31,
//             then fixed-priority W > LU > debug sharing with LU stall request.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter bit INIT_CLEAR   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            lu_valid,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    input  logic            dbg_valid,
    input  logic [4:0]      dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            init_busy,
    output logic            stall_req
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = INIT_CLEAR ? ST_INIT : ST_RUN;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    logic [0:0] state;
    logic [4:0] init_idx;
    logic [3:0] starve_cnt;

    logic w_req;
    logic lu_xfer;
    logic lu_blocked;

    assign w_req      = RegWriteW && (RdW != 5'd0);
    assign lu_xfer    = lu_valid && lu_ready;
    assign lu_blocked = lu_valid && !lu_ready;
    assign init_busy  = (state == ST_INIT);

    // Outputs are forced quiet while reset is held, even though state sits in INIT.
    always_comb begin
        rf_we     = 1'b0;
        rf_wa     = 5'd0;
        rf_wd     = '0;
        lu_ready  = 1'b0;
        dbg_ready = 1'b0;
        if (rst_n) begin
            if (state == ST_INIT) begin
                rf_we = 1'b1;
                rf_wa = init_idx;
            end else if (w_req) begin
                rf_we = 1'b1;
                rf_wa = RdW;
                rf_wd = ResultW;
            end else if (lu_valid) begin
                lu_ready = 1'b1;
                rf_we    = (lu_rd != 5'd0);
                rf_wa    = lu_rd;
                rf_wd    = lu_data;
            end else if (dbg_valid) begin
                dbg_ready = 1'b1;
                rf_we     = (dbg_rd != 5'd0);
                rf_wa     = dbg_rd;
                rf_wd     = dbg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            init_idx <= 5'd1;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 5'd1;
            if (init_idx == 5'd31) begin
                state <= ST_RUN;
            end
        end
    end

    // Clearing on transfer takes precedence over reaching the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            stall_req  <= 1'b0;
        end else begin
            if (lu_xfer || !lu_valid) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            if (lu_xfer) begin
                stall_req <= 1'b0;
            end else if (lu_blocked && (starve_cnt == LIMIT_M1)) begin
                stall_req <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_lu_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (lu_valid && !lu_ready) |=> lu_valid);
    a_dbg_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (dbg_valid && !dbg_ready) |=> dbg_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RdW = 5'd0;
    logic [31:0] ResultW = 32'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        lu_ready;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_rd = 5'd0;
    logic [31:0] dbg_data = 32'd0;
    logic        dbg_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_busy;
    logic        stall_req;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .init_busy(init_busy), .stall_req(stall_req)
    );

    // Advance one clock; inputs change at posedge+1, checks land at posedge+2.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if ({rf_we, rf_wa, rf_wd} !== 38'd0) begin
            fails++;
            $display("FAIL reset_write_port: got we=%0b wa=%0d wd=%0h want 0/0/0", rf_we, rf_wa, rf_wd);
        end
        tests++;
        if ({lu_ready, dbg_ready, stall_req, init_busy} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_flags: got lu_rdy=%0b dbg_rdy=%0b stall=%0b busy=%0b want 0 0 0 1",
                     lu_ready, dbg_ready, stall_req, init_busy);
        end
    endtask

    // Checks n clear cycles starting at x1; caller releases reset first.
    task automatic run_clear(input int n, input bit expect_done);
        #1;
        for (int i = 1; i <= n; i++) begin
            tests++;
            if (rf_we !== 1'b1 || rf_wa !== 5'(i) || rf_wd !== 32'd0 || init_busy !== 1'b1
                || lu_ready !== 1'b0 || dbg_ready !== 1'b0) begin
                fails++;
                $display("FAIL clear_cycle_%0d: got we=%0b wa=%0d wd=%0h busy=%0b lu_rdy=%0b dbg_rdy=%0b want 1 %0d 0 1 0 0",
                         i, rf_we, rf_wa, rf_wd, init_busy, lu_ready, dbg_ready, i);
            end
            @(posedge clk);
            #2;
        end
        if (expect_done) begin
            tests++;
            if (init_busy !== 1'b0) begin
                fails++;
                $display("FAIL clear_done: got init_busy=%0b want 0", init_busy);
            end
        end
    endtask

    task automatic test_init_clear();
        RegWriteW = 1'b1;
        RdW       = 5'd9;
        ResultW   = 32'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(31, 1'b1);
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'hFF) begin
            fails++;
            $display("FAIL first_run_w: got we=%0b wa=%0d wd=%0h want 1 9 ff", rf_we, rf_wa, rf_wd);
        end
        RegWriteW = 1'b0;
        #1;
        tests++;
        if ({rf_we, rf_wa, rf_wd} !== 38'd0) begin
            fails++;
            $display("FAIL idle_port: got we=%0b wa=%0d wd=%0h want 0/0/0", rf_we, rf_wa, rf_wd);
        end
    endtask

    task automatic test_w_priority();
        next_cycle();
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
        lu_valid  = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF || lu_ready !== 1'b0) begin
            fails++;
            $display("FAIL w_over_lu: got we=%0b wa=%0d wd=%0h lu_rdy=%0b want 1 5 deadbeef 0",
                     rf_we, rf_wa, rf_wd, lu_ready);
        end
        next_cycle();
        RegWriteW = 1'b0;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h1234 || lu_ready !== 1'b1) begin
            fails++;
            $display("FAIL lu_grant: got we=%0b wa=%0d wd=%0h lu_rdy=%0b want 1 7 1234 1",
                     rf_we, rf_wa, rf_wd, lu_ready);
        end
        next_cycle();
        lu_valid = 1'b0;
    endtask

    task automatic test_rd0_passthrough();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF;
        dbg_valid = 1'b1; dbg_rd = 5'd3; dbg_data = 32'hA5;
        #1;
        tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'hA5 || dbg_ready !== 1'b1 || lu_ready !== 1'b0) begin
            fails++;
            $display("FAIL w_rd0_dbg: got we=%0b wa=%0d wd=%0h dbg_rdy=%0b lu_rdy=%0b want 1 3 a5 1 0",
                     rf_we, rf_wa, rf_wd, dbg_ready, lu_ready);
        end
        next_cycle();
        dbg_valid = 1'b0;
        RegWriteW = 1'b0;
    endtask

    task automatic test_lu_over_dbg();
        lu_valid  = 1'b1; lu_rd = 5'd12; lu_data = 32'h11;
        dbg_valid = 1'b1; dbg_rd = 5'd12; dbg_data = 32'h22;
        #1;
        tests++;
        if (lu_ready !== 1'b1 || dbg_ready !== 1'b0 || rf_wd !== 32'h11) begin
            fails++;
            $display("FAIL lu_over_dbg: got lu_rdy=%0b dbg_rdy=%0b wd=%0h want 1 0 11", lu_ready, dbg_ready, rf_wd);
        end
        next_cycle();
        lu_valid = 1'b0;
        #1;
        tests++;
        if (dbg_ready !== 1'b1 || rf_wa !== 5'd12 || rf_wd !== 32'h22) begin
            fails++;
            $display("FAIL dbg_after_lu: got dbg_rdy=%0b wa=%0d wd=%0h want 1 12 22", dbg_ready, rf_wa, rf_wd);
        end
        next_cycle();
        dbg_valid = 1'b0;
    endtask

    task automatic test_starvation();
        RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h3;
        lu_valid  = 1'b1; lu_rd = 5'd9; lu_data = 32'h55;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (stall_req !== 1'b0 || lu_ready !== 1'b0) begin
                fails++;
                $display("FAIL starve_pre_%0d: got stall=%0b lu_rdy=%0b want 0 0", i, stall_req, lu_ready);
            end
            @(posedge clk);
            #2;
        end
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("FAIL starve_assert: got stall=%0b want 1", stall_req);
        end
        @(posedge clk);
        #2;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("FAIL starve_hold: got stall=%0b want 1", stall_req);
        end
        RegWriteW = 1'b0;
        #1;
        tests++;
        if (lu_ready !== 1'b1 || rf_wa !== 5'd9 || stall_req !== 1'b1) begin
            fails++;
            $display("FAIL starve_grant: got lu_rdy=%0b wa=%0d stall=%0b want 1 9 1", lu_ready, rf_wa, stall_req);
        end
        next_cycle();
        lu_valid = 1'b0;
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("FAIL starve_clear: got stall=%0b want 0", stall_req);
        end
    endtask

    task automatic test_lu_rd0();
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h77;
        #1;
        tests++;
        if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
            fails++;
            $display("FAIL lu_rd0: got lu_rdy=%0b we=%0b want 1 0", lu_ready, rf_we);
        end
        next_cycle();
        lu_valid = 1'b0;
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("FAIL lu_rd0_stall: got stall=%0b want 0", stall_req);
        end
    endtask

    task automatic test_reset_mid_init();
        next_cycle();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(9, 1'b0);
        tests++;
        if (rf_wa !== 5'd10 || init_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_init_idx: got wa=%0d busy=%0b want 10 1", rf_wa, init_busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (rf_we !== 1'b0 || rf_wa !== 5'd0 || init_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_init_reset: got we=%0b wa=%0d busy=%0b want 0 0 1", rf_we, rf_wa, init_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_clear(31, 1'b1);
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_w_priority();
        test_rd0_passthrough();
        test_lu_over_dbg();
        test_starvation();
        test_lu_rd0();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (we/addr/data) of the 32x32 register file in the 5-stage pipeline.
- After reset, it sequences a clear of x1..x31 to zero, because the register file has no reset.
- In normal operation it shares the write port among three requesters: the pipeline writeback stage (W), a long-latency unit (LU, mul/div), and a debug port.
- It raises a pipeline stall request when the LU is starved.

Parameters:
- XLEN, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles of blocked LU request before stall_req asserts; range 1..15.
- INIT_CLEAR, 1, 1 = run the post-reset clear sequence; 0 = enter RUN directly.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RegWriteW  in  1  W-stage write enable.
- RdW  in  5  W-stage destination register.
- ResultW  in  XLEN  W-stage write data.
- lu_valid  in  1  LU write request.
- lu_rd  in  5  LU destination register.
- lu_data  in  XLEN  LU write data.
- lu_ready  out  1  LU request accepted this cycle.
- dbg_valid  in  1  debug write request.
- dbg_rd  in  5  debug destination register.
- dbg_data  in  XLEN  debug write data.
- dbg_ready  out  1  debug request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- init_busy  out  1  clear in progress; hazard unit holds fetch/decode.
- stall_req  out  1  request to freeze the pipeline and bubble W.

Behaviour:
- State: INIT, RUN; init_idx (5 bit); starve_cnt; stall_req register.
- While rst_n=0:
  - state=INIT (or RUN if INIT_CLEAR=0), init_idx=1, starve_cnt=0, stall_req=0.
  - rf_we=0, rf_wa=0, rf_wd=0, lu_ready=0, dbg_ready=0.
  - init_busy=1 (0 if INIT_CLEAR=0).
- INIT:
  - Each cycle: rf_we=1, rf_wa=init_idx, rf_wd=0; init_idx increments.
  - After writing x31, next state is RUN.
  - Exactly 31 write cycles; x0 is never written.
  - All readies are 0 and RegWriteW is ignored; init_busy=1.
- RUN (init_busy=0): grant is combinational, same cycle, fixed priority W > LU > debug.
  - W wins if RegWriteW=1 && RdW!=0. Outputs rf_we=1, rf_wa=RdW, rf_wd=ResultW. lu_ready=0, dbg_ready=0.
  - Otherwise, LU wins if lu_valid=1: lu_ready=1.
  - Otherwise, debug wins if dbg_valid=1: dbg_ready=1.
  - rf_we=1 only for a granted request with rd!=0.
  - A granted request with rd=0 still completes its handshake (ready=1) but has rf_we=0.
  - W write with RdW=0: treated as no W request; the port is free for LU/debug that cycle.
  - No grant: rf_we=0; rf_wa and rf_wd are don't-care, and are driven 0.
- Handshake rules:
  - A transfer occurs when valid && ready.
  - Requesters hold valid/rd/data stable until accepted.
  - Dropping valid before acceptance is illegal (checker assertion).
- Starvation:
  - starve_cnt increments each cycle lu_valid && !lu_ready, saturating at STARVE_LIMIT.
  - It clears on an LU transfer or on !lu_valid.
  - stall_req is set on the edge where starve_cnt reaches STARVE_LIMIT.
  - stall_req is cleared on the edge following an LU transfer.
  - The arbiter never reorders priority. The pipeline responds to stall_req by bubbling W, and the LU wins the first cycle with no W write.
- Debug has no starvation protection and may wait indefinitely.
- Simultaneous events:
  - LU transfer and counter reaching the limit in the same cycle: clear wins, stall_req stays 0.
  - An LU and a debug request to the same rd in one cycle: the LU wins and debug waits.
- Reset asserted mid-INIT or mid-RUN: asynchronous return to reset values; the clear restarts at x1 after release.
- In-flight LU/debug requests are dropped by reset; requesters also reset.

Test Plan:
- Release rst_n, INIT_CLEAR=1 -> rf_we=1 for 31 cycles with rf_wa=1..31, rf_wd=0; init_busy falls on cycle 32; lu_ready/dbg_ready stay 0 throughout.
- RUN: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF while lu_valid=1 -> rf_wa=5, rf_wd=0xDEADBEEF, lu_ready=0. Next cycle RegWriteW=0, lu_rd=7, lu_data=0x1234 -> lu_ready=1, rf_wa=7.
- RegWriteW=1 with RdW=0, plus dbg_valid=1, dbg_rd=3, dbg_data=0xA5 -> rf_we=1, rf_wa=3, dbg_ready=1.
- STARVE_LIMIT=4, lu_valid held with RegWriteW=1 every cycle -> stall_req=1 after 4 blocked cycles. Then drop RegWriteW -> lu_ready=1 that cycle; stall_req=0 the next cycle.
- LU request with lu_rd=0 and no W write -> lu_ready=1, rf_we=0, starve_cnt=0.
- Assert rst_n=0 at INIT cycle 10 and release -> clear restarts at rf_wa=1 and runs the full 31 cycles.
